// File: rtl/plot_receiver.sv
// plot_receiver: 8-entry pixel FIFO feeding one framebuffer write register (addr = y*160 + x).
// Define PLOT_BOUNDS_CHECK_EN to silently discard off-screen pixels (x>=160 or y>=120).
`default_nettype none

module plot_receiver (
   input  logic        clk,
   input  logic        resetn,
   input  logic        plot,
   input  logic [7:0]  x_in,
   input  logic [6:0]  y_in,
   input  logic [2:0]  colour_in,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [14:0] mem_addr,
   output logic [2:0]  mem_data,
   output logic        full,
   output logic        overflow,
   output logic [7:0]  drop_count
);

   localparam int DEPTH = 8;

   // FIFO entry layout: {x[7:0], y[6:0], colour[2:0]}
   logic [17:0] fifo_q [0:DEPTH-1];
   logic [17:0] fifo_d [0:DEPTH-1];
   logic [2:0]  wr_ptr_q, wr_ptr_d;
   logic [2:0]  rd_ptr_q, rd_ptr_d;
   logic [3:0]  count_q, count_d;
   logic        valid_q, valid_d;
   logic [14:0] addr_q, addr_d;
   logic [2:0]  data_q, data_d;
   logic        overflow_q, overflow_d;
   logic [7:0]  drop_q, drop_d;

   logic        in_bounds;
   logic        push_req;
   logic        push;
   logic        pop;
   logic [7:0]  head_x;
   logic [14:0] head_y;
   logic [14:0] head_addr;

   always_comb begin
`ifdef PLOT_BOUNDS_CHECK_EN
      in_bounds = (x_in < 8'd160) && (y_in < 7'd120);
`else
      in_bounds = 1'b1;
`endif
      push_req  = plot && in_bounds;
      pop       = (count_q != 4'd0) && (!valid_q || mem_ready);
      // A full FIFO still accepts when the head leaves on the same edge
      push      = push_req && ((count_q != 4'd8) || pop);

      head_x    = fifo_q[rd_ptr_q][17:10];
      head_y    = {8'd0, fifo_q[rd_ptr_q][9:3]};
      head_addr = (head_y << 7) + (head_y << 5) + {7'd0, head_x};

      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      valid_d    = valid_q;
      addr_d     = addr_q;
      data_d     = data_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;

      if (pop) begin
         addr_d   = head_addr;
         data_d   = fifo_q[rd_ptr_q][2:0];
         valid_d  = 1'b1;
         rd_ptr_d = rd_ptr_q + 3'd1;
      end else if (valid_q && mem_ready) begin
         valid_d  = 1'b0;
      end

      if (push) begin
         fifo_d[wr_ptr_q] = {x_in, y_in, colour_in};
         wr_ptr_d         = wr_ptr_q + 3'd1;
      end

      count_d = count_q + {3'd0, push} - {3'd0, pop};

      if (push_req && !push) begin
         overflow_d = 1'b1;
         if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   assign mem_we     = valid_q;
   assign mem_addr   = addr_q;
   assign mem_data   = data_q;
   assign full       = (count_q == 4'd8);
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

endmodule

`default_nettype wire
